// File: rtl/mips_pkg.sv
// mips_pkg: control-bit indices and MEM-stage handshake state encoding.
package mips_pkg;
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/mem_handshake_fsm.sv
// mem_handshake_fsm: data-memory req/ack sequencer with request registers and stall generation.
// MEM_TIMEOUT_EN adds a WAIT-cycle counter that aborts an unanswered request and sets sticky mem_err.
module mem_handshake_fsm
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memop,
  input  logic        we_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        stall_out,
  output logic        done,
  output logic [31:0] rdata,
  output logic        mem_err
);
  mem_state_t  state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: if (memop) begin
        state_d = WAIT;
        req_d   = 1'b1;
        we_d    = we_in;
        addr_d  = addr_in;
        wdata_d = wdata_in;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: if (mem_ack) begin
        state_d = DONE;
        req_d   = 1'b0;
        rdata_d = we_q ? '0 : mem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        req_d   = 1'b0;
        rdata_d = '0;
        err_d   = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_err = err_q;
`else
  assign mem_err = 1'b0;
`endif
  assign stall_out = (state_q == IDLE && memop) || state_q == WAIT;
  assign done      = state_q == DONE;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS memory-access stage, branch resolution and MEM/WB pipeline register.
// Optional MEM_TIMEOUT_EN aborts memory requests unanswered for TIMEOUT_CYCLES WAIT cycles.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  wb_ctl_in,
  input  logic [2:0]  m_ctl_in,
  input  logic [31:0] add_result_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  mux_out_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_out,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic [1:0]  wb_ctl_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        mem_err
);
  logic        memop, done;
  logic [31:0] cap_rdata;
  logic [1:0]  wb_q, wb_d;
  logic [31:0] rd_q, rd_d, alu_q, alu_d;
  logic [4:0]  reg_q, reg_d;
  assign memop = m_ctl_in[MEMREAD] | m_ctl_in[MEMWRITE];
  mem_handshake_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .memop     (memop),
    .we_in     (m_ctl_in[MEMWRITE]),
    .addr_in   (alu_result_in),
    .wdata_in  (read_data2_in),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall_out (stall_out),
    .done      (done),
    .rdata     (cap_rdata),
    .mem_err   (mem_err)
  );
  // a stalled cycle writes a bubble: only the write-back control is cleared
  always_comb begin
    wb_d  = stall_out ? 2'b00 : wb_ctl_in;
    rd_d  = stall_out ? rd_q : (done ? cap_rdata : 32'h0);
    alu_d = stall_out ? alu_q : alu_result_in;
    reg_d = stall_out ? reg_q : mux_out_in;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_q  <= '0;
      rd_q  <= '0;
      alu_q <= '0;
      reg_q <= '0;
    end else begin
      wb_q  <= wb_d;
      rd_q  <= rd_d;
      alu_q <= alu_d;
      reg_q <= reg_d;
    end
  end
  assign pc_src         = m_ctl_in[BRANCH] & zero_in & ~stall_out;
  assign branch_target  = add_result_in;
  assign wb_ctl_out     = wb_q;
  assign read_data_out  = rd_q;
  assign alu_result_out = alu_q;
  assign write_reg_out  = reg_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus hand-written load/store/reset/timeout sequences.
module tb_mem_wb_stage;
  logic        clk = 1'b0, reset = 1'b0;
  logic [1:0]  wb_ctl_in = '0;
  logic [2:0]  m_ctl_in = '0;
  logic [31:0] add_result_in = '0, alu_result_in = '0, read_data2_in = '0, mem_rdata = '0;
  logic        zero_in = 1'b0, mem_ack = 1'b0;
  logic [4:0]  mux_out_in = '0;
  logic        mem_req, mem_we, stall_out, pc_src, mem_err;
  logic [31:0] mem_addr, mem_wdata, branch_target, read_data_out, alu_result_out;
  logic [1:0]  wb_ctl_out;
  logic [4:0]  write_reg_out;
  int n_chk = 0, n_fail = 0;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .wb_ctl_in(wb_ctl_in), .m_ctl_in(m_ctl_in),
    .add_result_in(add_result_in), .zero_in(zero_in), .alu_result_in(alu_result_in),
    .read_data2_in(read_data2_in), .mux_out_in(mux_out_in), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall_out(stall_out), .pc_src(pc_src),
    .branch_target(branch_target), .wb_ctl_out(wb_ctl_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        pc;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] dst);
    wb_ctl_in = wb; m_ctl_in = m; alu_result_in = alu; read_data2_in = rd2; mux_out_in = dst;
    #1;
  endtask

  initial begin
    vecs[0] = '{2'b10, 3'b000, 32'h0,   1'b0, 32'h0000_1234, 5'd5,  1'b0};
    vecs[1] = '{2'b00, 3'b100, 32'h100, 1'b1, 32'h0,         5'd0,  1'b1};
    vecs[2] = '{2'b00, 3'b100, 32'h104, 1'b0, 32'h1,         5'd1,  1'b0};
    vecs[3] = '{2'b11, 3'b000, 32'h0,   1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0};
    // reset with nonzero inputs presented
    present(2'b11, 3'b000, 32'hAAAA_5555, 32'h1, 5'd9);
    tick(); tick();
    chk("rst_wb", 32'(wb_ctl_out), 32'h0);
    chk("rst_alu", alu_result_out, 32'h0);
    chk("rst_wreg", 32'(write_reg_out), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_err", 32'(mem_err), 32'h0);
    reset = 1'b1;
    // table of single-cycle non-memory instructions
    for (int i = 0; i < 4; i++) begin
      present(vecs[i].wb, vecs[i].m, vecs[i].alu, 32'h0, vecs[i].dst);
      add_result_in = vecs[i].add; zero_in = vecs[i].zero; mem_ack = 1'b1;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_out), 32'h0);
      chk($sformatf("v%0d_pcsrc", i), 32'(pc_src), 32'(vecs[i].pc));
      chk($sformatf("v%0d_target", i), branch_target, vecs[i].add);
      tick();
      chk($sformatf("v%0d_wb", i), 32'(wb_ctl_out), 32'(vecs[i].wb));
      chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].alu);
      chk($sformatf("v%0d_wreg", i), 32'(write_reg_out), 32'(vecs[i].dst));
      chk($sformatf("v%0d_rdata", i), read_data_out, 32'h0);
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'h0);
    end
    mem_ack = 1'b0; zero_in = 1'b0;
    // load with branch set and zero=1: stalled branch must not redirect
    present(2'b11, 3'b110, 32'h40, 32'h0, 5'd7);
    zero_in = 1'b1; add_result_in = 32'h200;
    #1;
    chk("ld_stall_n", 32'(stall_out), 32'h1);
    chk("ld_pcsrc_stalled", 32'(pc_src), 32'h0);
    chk("ld_target", branch_target, 32'h200);
    chk("ld_req_n", 32'(mem_req), 32'h0);
    tick();
    chk("ld_req_w1", 32'(mem_req), 32'h1);
    chk("ld_addr_w1", mem_addr, 32'h40);
    chk("ld_we_w1", 32'(mem_we), 32'h0);
    chk("ld_stall_w1", 32'(stall_out), 32'h1);
    chk("ld_bubble_w1", 32'(wb_ctl_out), 32'h0);
    tick();
    chk("ld_req_w2", 32'(mem_req), 32'h1);
    chk("ld_addr_w2", mem_addr, 32'h40);
    chk("ld_stall_w2", 32'(stall_out), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("ld_stall_done", 32'(stall_out), 32'h0);
    chk("ld_req_done", 32'(mem_req), 32'h0);
    chk("ld_bubble_done", 32'(wb_ctl_out), 32'h0);
    tick();
    chk("ld_rdata", read_data_out, 32'hDEAD_BEEF);
    chk("ld_wb", 32'(wb_ctl_out), 32'h3);
    chk("ld_alu", alu_result_out, 32'h40);
    chk("ld_wreg", 32'(write_reg_out), 32'h7);
    chk("ld_no_reissue", 32'(mem_req), 32'h0);
    // store, acked on the first WAIT cycle with junk read data
    zero_in = 1'b0;
    present(2'b00, 3'b001, 32'h80, 32'h55AA, 5'd0);
    tick();
    chk("st_req", 32'(mem_req), 32'h1);
    chk("st_we", 32'(mem_we), 32'h1);
    chk("st_addr", mem_addr, 32'h80);
    chk("st_wdata", mem_wdata, 32'h55AA);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("st_rdata", read_data_out, 32'h0);
    chk("st_alu", alu_result_out, 32'h80);
    // both read and write set: treated as a write
    present(2'b01, 3'b011, 32'hC0, 32'h77, 5'd3);
    tick();
    chk("rw_we", 32'(mem_we), 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("rw_rdata", read_data_out, 32'h0);
    chk("rw_wb", 32'(wb_ctl_out), 32'h1);
    // reset in the middle of WAIT
    present(2'b11, 3'b010, 32'h44, 32'h0, 5'd4);
    tick();
    chk("mr_req_pre", 32'(mem_req), 32'h1);
    reset = 1'b0;
    present(2'b10, 3'b000, 32'h5, 32'h0, 5'd2);
    tick();
    chk("mr_req", 32'(mem_req), 32'h0);
    chk("mr_stall", 32'(stall_out), 32'h0);
    chk("mr_wb", 32'(wb_ctl_out), 32'h0);
    chk("mr_alu", alu_result_out, 32'h0);
    chk("mr_rdata", read_data_out, 32'h0);
    chk("mr_wreg", 32'(write_reg_out), 32'h0);
    chk("mr_addr", mem_addr, 32'h0);
    reset = 1'b1;
    tick();
    chk("mr_after_wb", 32'(wb_ctl_out), 32'h2);
    chk("mr_no_retry", 32'(mem_req), 32'h0);
`ifdef MEM_TIMEOUT_EN
    // ack arriving on the final allowed WAIT cycle wins over the timeout
    present(2'b10, 3'b010, 32'h48, 32'h0, 5'd6);
    tick(); tick(); tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("to_late_ack_err", 32'(mem_err), 32'h0);
    chk("to_late_ack_rdata", read_data_out, 32'hCAFE_F00D);
    // no ack: abort after four WAIT cycles
    present(2'b11, 3'b010, 32'h4C, 32'h0, 5'd8);
    mem_rdata = 32'hBAD0_BAD0;
    tick(); tick(); tick();
    chk("to_stall_w3", 32'(stall_out), 32'h1);
    tick();
    chk("to_stall_w4", 32'(stall_out), 32'h1);
    tick();
    chk("to_stall_done", 32'(stall_out), 32'h0);
    chk("to_req_done", 32'(mem_req), 32'h0);
    chk("to_err", 32'(mem_err), 32'h1);
    tick();
    chk("to_rdata", read_data_out, 32'h0);
    chk("to_wb", 32'(wb_ctl_out), 32'h3);
    present(2'b10, 3'b000, 32'h9, 32'h0, 5'd1);
    tick();
    chk("to_err_sticky", 32'(mem_err), 32'h1);
`else
    // without a timeout the stall lasts until ack
    present(2'b11, 3'b010, 32'h4C, 32'h0, 5'd8);
    for (int i = 0; i < 20; i++) tick();
    chk("nt_stall", 32'(stall_out), 32'h1);
    chk("nt_req", 32'(mem_req), 32'h1);
    chk("nt_err", 32'(mem_err), 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_CAFE;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("nt_rdata", read_data_out, 32'h0BAD_CAFE);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage and MEM/WB pipeline register for the MIPS datapath: consumes the EX/MEM bundle, performs the data-memory access over a req/ack handshake, resolves the branch decision, and registers results for write-back. Stalls the upstream pipeline while a memory access is outstanding and inserts a bubble into MEM/WB during the stall.

## Interface
- TIMEOUT_CYCLES, 16, cycles in WAIT without mem_ack before abort (used only with MEM_TIMEOUT_EN)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- wb_ctl_in  in  2  [1]=RegWrite, [0]=MemtoReg
- m_ctl_in  in  3  [2]=Branch, [1]=MemRead, [0]=MemWrite
- add_result_in  in  32  branch target
- zero_in  in  1  ALU zero flag
- alu_result_in  in  32  ALU result / memory address
- read_data2_in  in  32  store data
- mux_out_in  in  5  destination register
- mem_req  out  1  memory request, registered
- mem_we  out  1  1=write, 0=read
- mem_addr  out  32  word address, registered
- mem_wdata  out  32  store data, registered
- mem_ack  in  1  memory completion, sampled in WAIT
- mem_rdata  in  32  read data, valid with mem_ack
- stall_out  out  1  upstream must hold EX/MEM contents
- pc_src  out  1  branch taken
- branch_target  out  32  = add_result_in
- wb_ctl_out  out  2  registered write-back control
- read_data_out  out  32  registered load data
- alu_result_out  out  32  registered ALU result
- write_reg_out  out  5  registered destination register
- mem_err  out  1  sticky timeout flag

## Operation
- FSM states IDLE, WAIT, DONE. Reset state IDLE.
- memop = m_ctl_in[1] | m_ctl_in[0]. Both set: treated as write; read_data_out = 0.
- IDLE, !memop: MEM/WB loads inputs (read_data_out = 0); stay IDLE.
- IDLE, memop: stall_out=1; latch mem_addr=alu_result_in, mem_wdata=read_data2_in, mem_we=m_ctl_in[0]; mem_req<=1; MEM/WB loads bubble (wb_ctl_out=0, other fields hold); -> WAIT.
- WAIT: stall_out=1, bubble. mem_ack=1: capture mem_rdata (0 for writes), mem_req<=0, -> DONE. Else remain.
- DONE: stall_out=0; MEM/WB loads wb_ctl_in, captured read data, alu_result_in, mux_out_in; -> IDLE. Prevents reissuing the completed op.
- stall_out = (IDLE & memop) | WAIT; combinational.
- pc_src = m_ctl_in[2] & zero_in & !stall_out; combinational.
- mem_ack outside WAIT ignored.
- Reset (reset=0 at clk edge), including mid-WAIT: state IDLE, mem_req/mem_we=0, mem_addr/mem_wdata=0, all MEM/WB outputs 0, captured data 0, mem_err=0. Abandoned request not retried.

## Timing
- Non-memory instruction: MEM/WB outputs valid 1 cycle after presentation.
- Memory op presented cycle N: mem_req high from N+1; ack at cycle N+k (k>=1) -> DONE at N+k+1 -> outputs valid N+k+2. Minimum 3-cycle latency.
- stall_out high cycles N..N+k; upstream advances at end of N+k+1.
- mem_req, mem_addr, mem_wdata, mem_we stable throughout WAIT.

## Configuration
- MEM_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ack; reaching TIMEOUT_CYCLES-1 without ack forces DONE with read data 0, mem_req<=0, mem_err<=1 (sticky until reset). Ack on that same cycle wins; no error.
- Undefined: WAIT indefinitely; no counter; mem_err tied 0.

## Structure
- Shared mips_pkg: control-bit index constants (REGWRITE, MEMTOREG, BRANCH, MEMREAD, MEMWRITE), state typedef mem_state_t {IDLE, WAIT, DONE}.
- Sub-module mem_handshake_fsm: FSM, request registers, timeout counter, stall_out; top holds MEM/WB register and branch logic.

## Test plan
- ALU op wb_ctl=2'b10, alu=0x0000_1234, dst=5: next cycle wb_ctl_out=2'b10, alu_result_out=0x1234, write_reg_out=5, stall_out never high.
- Load addr 0x40, ack 2 cycles after mem_req rises with rdata 0xDEADBEEF: stall 3 cycles, mem_req held, read_data_out=0xDEADBEEF, wb_ctl_out=0 during stall.
- Store addr 0x80, data 0x55AA: mem_we=1, mem_addr=0x80, mem_wdata=0x55AA while mem_req; read_data_out=0.
- Branch with zero=1, target 0x100: pc_src=1, branch_target=0x100; same with memop stalled -> pc_src=0.
- reset=0 mid-WAIT: next cycle mem_req=0, stall_out=0 (non-mem input), all outputs 0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack: abort after 4 WAIT cycles, mem_err=1 sticky, read_data_out=0; undefined: stall persists.
